// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 shift-add multiplier sequencer.
// Holds operand widths, FSM state encoding and partial-product shift selects,
// plus a helper mapping the step counter to its shift amount.
package mult_pkg;

  localparam int DW = 8;        // operand width (only 8 supported)
  localparam int NW = DW / 2;   // nibble width
  localparam int PW = 2 * DW;   // product / accumulator width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH0 = 2'd0,
    SH4 = 2'd1,
    SH8 = 2'd2
  } sh_sel_t;

  // Step 0 is lo*lo, steps 1/2 are the cross terms, step 3 is hi*hi.
  function automatic sh_sel_t sh_sel_of(input logic [1:0] cnt);
    sh_sel_t sel;
    case (cnt)
      2'd0:    sel = SH0;
      2'd1,
      2'd2:    sel = SH4;
      default: sel = SH8;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mult8x8_seq_ctrl_if.sv
// Bus between the multiplier sequencer and its surroundings.
// master: control/accumulator side (drives start, operands, acc_q feedback).
// slave : sequencer side (drives acc_datain/acc_clk_ena, busy, done, state_out).
interface mult8x8_seq_ctrl_if;
  import mult_pkg::*;

  logic          start;
  logic [DW-1:0] dataa;
  logic [DW-1:0] datab;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_datain;
  logic          acc_clk_ena;
  logic          busy;
  logic          done;
  logic [1:0]    state_out;

  modport master (
    output start, dataa, datab, acc_q,
    input  acc_datain, acc_clk_ena, busy, done, state_out
  );

  modport slave (
    input  start, dataa, datab, acc_q,
    output acc_datain, acc_clk_ena, busy, done, state_out
  );

endinterface

// File: rtl/mult4x4.sv
// Combinational 4x4 -> 8 unsigned multiplier for one nibble partial product.
// Ports: a, b (4-bit nibbles) in; p (8-bit product) out. Zero latency.
// No flow control; purely combinational.
module mult4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequencing front-end of the 8x8 shift-add multiplier: latches operands on
// start, then over four CALC cycles feeds shifted nibble partial products into
// the external 16-bit accumulator; pulses done once the product sits in acc_q.
// Ports: clk, sclr_n (async active-low, shared with the accumulator), bus (slave).
// Latency: start at edge N, accumulator loads N+1..N+4, done in cycle after N+4.
// start is ignored outside IDLE; operands are registered so input changes mid-run have no effect.
module mult8x8_seq_ctrl
  import mult_pkg::*;
#(
  parameter int DW = mult_pkg::DW
) (
  input  logic              clk,
  input  logic              sclr_n,
  mult8x8_seq_ctrl_if.slave bus
);

  localparam int HW = DW / 2;
  localparam int AW = 2 * DW;

  state_t        state;
  logic [1:0]    cnt;
  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic          busy_r;
  logic          done_r;
  logic          ena_r;

  logic [HW-1:0] nib_a;
  logic [HW-1:0] nib_b;
  logic [DW-1:0] pp;
  logic [AW-1:0] pp_ext;
  logic [AW-1:0] shifted;
  logic [AW-1:0] datain;
  sh_sel_t       sh_sel;

  // FSM with registered status outputs; outputs are set on the same edge as
  // the state they describe so they never lag the state register.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      a_r    <= '0;
      b_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ena_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_r    <= bus.dataa;
            b_r    <= bus.datab;
            cnt    <= 2'd0;
            state  <= ST_CALC;
            busy_r <= 1'b1;
            ena_r  <= 1'b1;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            cnt    <= 2'd0;
            state  <= ST_DONE;
            busy_r <= 1'b0;
            ena_r  <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= 2'd0;
          busy_r <= 1'b0;
          ena_r  <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // cnt[0] picks the high nibble of a, cnt[1] the high nibble of b:
  // 0 -> lo*lo, 1 -> hi(a)*lo(b), 2 -> lo(a)*hi(b), 3 -> hi*hi.
  assign nib_a  = cnt[0] ? a_r[DW-1:HW] : a_r[HW-1:0];
  assign nib_b  = cnt[1] ? b_r[DW-1:HW] : b_r[HW-1:0];
  assign sh_sel = sh_sel_of(cnt);

  mult4x4 u_mult4x4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  assign pp_ext = {{DW{1'b0}}, pp};

  always_comb begin
    shifted = '0;
    datain  = '0;
    case (sh_sel)
      SH0:     shifted = pp_ext;
      SH4:     shifted = pp_ext << HW;
      SH8:     shifted = pp_ext << DW;
      default: shifted = '0;
    endcase
    if (state == ST_CALC) begin
      // First step overwrites the accumulator, so no separate clear cycle.
      if (sh_sel == SH0) datain = shifted;
      else               datain = bus.acc_q + shifted;
    end
  end

  assign bus.acc_datain  = datain;
  assign bus.acc_clk_ena = ena_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.state_out   = state;

endmodule
